mem_arbiter: RTL

Two-port arbiter sharing the single memory-controller handshake (valid / rw / ready) between the instruction-fetch requester and the load/store data requester of the control unit. It latches the winning request, drives one memory transaction at a time, returns read data with a one-cycle acknowledge, and flags transactions the memory never completes. It sits between the control unit and the memory controller.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and grant encodings for the fetch/data memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic ARB_GRANT_FETCH = 1'b0;
    localparam logic ARB_GRANT_DATA  = 1'b1;

    // Wide enough for the largest TIMEOUT value (255).
    localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory handshake between fetch and data requesters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_valid,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          f_ack,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          grant
);

    localparam logic [ARB_CNT_W-1:0] TIMEOUT_CNT = ARB_CNT_W'(TIMEOUT);

    arb_state_t             state;
    arb_state_t             next_state;
    logic [ARB_CNT_W-1:0]   cnt;
    logic                   last_served;
    logic                   pick_grant;
    logic                   any_req;
    logic                   timeout_hit;

    assign any_req     = f_req | d_req;
    assign timeout_hit = (cnt == TIMEOUT_CNT);

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        pick_grant = ARB_GRANT_FETCH;
        if (f_req && d_req) begin
            pick_grant = (last_served == ARB_GRANT_DATA) ? ARB_GRANT_FETCH : ARB_GRANT_DATA;
        end else if (d_req) begin
            pick_grant = ARB_GRANT_DATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = BUSY;
                end
            end
            // Completion is checked first so a ready on the timeout cycle still succeeds.
            BUSY: begin
                if (mem_ready || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Every output is a register updated on the transition out of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid   <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            f_ack       <= 1'b0;
            d_ack       <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            grant       <= ARB_GRANT_FETCH;
            cnt         <= '0;
            last_served <= ARB_GRANT_DATA;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (next_state == BUSY) begin
                        mem_valid <= 1'b1;
                        busy      <= 1'b1;
                        grant     <= pick_grant;
                        cnt       <= '0;
                        if (pick_grant == ARB_GRANT_FETCH) begin
                            mem_rw    <= 1'b1;
                            mem_addr  <= f_addr;
                            mem_wdata <= '0;
                        end else begin
                            mem_rw    <= d_rw;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (next_state == RESP) begin
                        mem_valid <= 1'b0;
                        f_ack     <= (grant == ARB_GRANT_FETCH);
                        d_ack     <= (grant == ARB_GRANT_DATA);
                        if (mem_ready) begin
                            rdata <= mem_rw ? mem_rdata : '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy        <= 1'b0;
                    last_served <= grant;
                end
                default: begin
                    mem_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
